spm_program_loader: RTL and testbench
=====================================

SPM_PROGRAM_LOADER -- requirements
Module: spm_program_loader

Interface
REQ-001 Parameter word_size, default 8, data and address width of the SPM memory port.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  word_size  byte stream from the host.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  loader accepts in_data; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-007 mem_addr  output  word_size  memory write address.
REQ-008 mem_data  output  word_size  memory write data.
REQ-009 mem_write  output  1  one-cycle write strobe to the SPM memory.
REQ-010 cpu_rst  output  1  active-low reset driven to RISC_SPM.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky flag for an unknown command byte.

Function
REQ-013 States: IDLE, GET_ADDR, GET_LEN, LOAD, FLUSH.
REQ-014 IDLE accepts one command byte; 8'hA5 -> GET_ADDR; 8'h5A -> FLUSH; 8'hC3 -> stay IDLE, cpu_rst=1 next cycle; any other value -> stay IDLE, err=1.
REQ-015 Accepting 8'hA5 or 8'h5A drives cpu_rst=0 on the next edge, and it stays low until a later 8'hC3 is accepted.
REQ-016 Accepting any valid command (A5/5A/C3) clears err.
REQ-017 GET_ADDR accepts one byte into the address counter -> GET_LEN.
REQ-018 GET_LEN accepts one byte N into the length counter -> LOAD; N=0 means 256 bytes.
REQ-019 LOAD accepts N payload bytes; for each byte accepted at edge t, mem_write=1, mem_addr=current address, mem_data=byte during cycle t+1 (registered, one-cycle latency).
REQ-020 The address counter increments by 1 per accepted payload byte, modulo 2^word_size (255 wraps to 0).
REQ-021 After the Nth payload byte, the state returns to IDLE, and a new command is accepted at the earliest on the following edge.
REQ-022 in_ready = 1 in IDLE, GET_ADDR, GET_LEN, and LOAD; 0 in FLUSH and while rst=0.
REQ-023 With in_valid=0, the FSM holds its state and counters, and mem_write=0 (gaps are allowed at any point).
REQ-024 FLUSH writes 0 to addresses 0..255 in ascending order, one per cycle (256 consecutive mem_write cycles), then returns to IDLE.
REQ-025 mem_write is never high for more than one cycle per accepted payload byte outside FLUSH.
REQ-026 busy is combinational from state; mem_addr, mem_data, mem_write, cpu_rst, and err are registered.

Reset
REQ-027 rst=0 asynchronously forces: state=IDLE, counters=0, mem_addr=0, mem_data=0, mem_write=0, cpu_rst=0, err=0, busy=0.
REQ-028 Reset mid-LOAD or mid-FLUSH aborts the frame with no further writes; after rst=1, the first accepted byte is a command.
REQ-029 After reset deassertion, the CPU stays held (cpu_rst=0) until 8'hC3 is accepted.

Verification
REQ-030 Reset release, then stream 5A -> in_ready=0 for 256 cycles; mem_write high for 256 consecutive cycles with addr 0..255 and data 0; then busy=0.
REQ-031 Stream A5,00,05,50,81,52,80,28 -> writes [0]=50h,[1]=81h,[2]=52h,[3]=80h,[4]=28h, each one cycle after acceptance; then send C3 -> cpu_rst=1 and the CPU executes READ R0,[129].
REQ-032 A5,FE,03,11,22,33 with in_valid toggling every other cycle -> writes FE=11h, FF=22h, 00=33h (wrap); no write during gaps.
REQ-033 Command 77h -> err=1 and state stays IDLE; then C3 -> err=0 and cpu_rst=1.
REQ-034 A5,8B,00 followed by 256 bytes -> 256 writes starting at 8Bh and wrapping to 8Ah; assert rst=0 after byte 10 of a repeat frame -> mem_write=0 immediately, and cpu_rst=0.

Source files
------------

// File: rtl/spm_program_loader.sv
// spm_program_loader: host byte-stream loader for the RISC_SPM scratchpad.
// Command bytes: A5 = load frame (addr, len, payload), 5A = zero the whole
// memory, C3 = release the CPU. Any other command sets a sticky error.
module spm_program_loader #(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [word_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_LEN, LOAD, FLUSH} state_t;

  localparam logic [word_size-1:0] CMD_LOAD  = word_size'(8'hA5);
  localparam logic [word_size-1:0] CMD_FLUSH = word_size'(8'h5A);
  localparam logic [word_size-1:0] CMD_RUN   = word_size'(8'hC3);
  localparam logic [word_size-1:0] ONE       = word_size'(1);

  state_t               state, state_n;
  logic [word_size-1:0] addr_cnt, addr_n;
  // Remaining payload bytes; a length byte of 0 wraps through all ones, so it
  // naturally means a full 2^word_size frame.
  logic [word_size-1:0] len_cnt, len_n;
  logic [word_size-1:0] maddr_n, mdata_n;
  logic                 mwr_n, cpu_rst_n, err_n;
  logic                 take;

  // Handshake: FLUSH owns the memory port, so the host is stalled there.
  assign in_ready = rst && (state != FLUSH);
  assign busy     = (state != IDLE);
  assign take     = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and next-output decode; write strobe defaults low every cycle
  always_comb begin
    state_n   = state;
    addr_n    = addr_cnt;
    len_n     = len_cnt;
    maddr_n   = mem_addr;
    mdata_n   = mem_data;
    mwr_n     = 1'b0;
    cpu_rst_n = cpu_rst;
    err_n     = err;
    case (state)
      IDLE: if (take) begin
        if (in_data == CMD_LOAD) begin
          state_n   = GET_ADDR;
          cpu_rst_n = 1'b0;
          err_n     = 1'b0;
        end else if (in_data == CMD_FLUSH) begin
          state_n   = FLUSH;
          addr_n    = '0;
          cpu_rst_n = 1'b0;
          err_n     = 1'b0;
        end else if (in_data == CMD_RUN) begin
          cpu_rst_n = 1'b1;
          err_n     = 1'b0;
        end else begin
          err_n     = 1'b1;
        end
      end
      GET_ADDR: if (take) begin
        addr_n  = in_data;
        state_n = GET_LEN;
      end
      GET_LEN: if (take) begin
        len_n   = in_data;
        state_n = LOAD;
      end
      LOAD: if (take) begin
        mwr_n   = 1'b1;
        maddr_n = addr_cnt;
        mdata_n = in_data;
        addr_n  = addr_cnt + ONE;
        len_n   = len_cnt - ONE;
        if (len_cnt == ONE) state_n = IDLE;
      end
      FLUSH: begin
        mwr_n   = 1'b1;
        maddr_n = addr_cnt;
        mdata_n = '0;
        addr_n  = addr_cnt + ONE;
        if (addr_cnt == '1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters and registered memory-port / CPU-control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt  <= '0;
      len_cnt   <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      cpu_rst   <= 1'b0;
      err       <= 1'b0;
    end else begin
      addr_cnt  <= addr_n;
      len_cnt   <= len_n;
      mem_addr  <= maddr_n;
      mem_data  <= mdata_n;
      mem_write <= mwr_n;
      cpu_rst   <= cpu_rst_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_spm_program_loader.sv
// Scoreboard bench for spm_program_loader: stimulus pushes expected writes
// (address, data, cycle) into a queue; a negedge monitor pops and compares.
module tb_spm_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_write;
  logic       cpu_rst;
  logic       busy;
  logic       err;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   npass  = 0;
  int   ntotal = 0;

  spm_program_loader #(.word_size(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write(mem_write), .cpu_rst(cpu_rst), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle stamp: a byte accepted at edge N is written during cycle N
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every observed write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst && mem_write) begin
      if (sbq.size() == 0) begin
        chk("spurious_write_addr", int'(mem_addr), -1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("write_addr", int'(mem_addr), int'(e.a));
        chk("write_data", int'(mem_data), int'(e.d));
        chk("write_cycle", cyc, e.c);
      end
    end
  end

  // Present one byte and hold it until accepted; bounded wait on in_ready
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.a = a; e.d = d; e.c = c;
    sbq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] p31 [5];
    logic [7:0] p32 [3];
    logic [7:0] b;
    int         c;
    p31 = '{8'h50, 8'h81, 8'h52, 8'h80, 8'h28};
    p32 = '{8'h11, 8'h22, 8'h33};

    // Reset state
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_cpu_rst", int'(cpu_rst), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_cpu_held", int'(cpu_rst), 0);

    // Flush: 256 zero writes, addresses 0..255, host stalled throughout
    send(8'h5A);
    c = cyc;
    for (int i = 0; i < 256; i++) push(8'(i), 8'h00, c + 1 + i);
    chk("flush_busy", int'(busy), 1);
    chk("flush_in_ready_first", int'(in_ready), 0);
    repeat (255) begin @(posedge clk); #1; end
    chk("flush_in_ready_last", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("flush_done_busy", int'(busy), 0);
    chk("flush_done_in_ready", int'(in_ready), 1);

    // Load 5-byte program at 0, then release the CPU
    send(8'hA5); send(8'h00); send(8'h05);
    for (int i = 0; i < 5; i++) begin
      send(p31[i]);
      push(8'(i), p31[i], cyc);
      if (i == 3) chk("load_busy_mid", int'(busy), 1);
    end
    chk("load_done_busy", int'(busy), 0);
    chk("load_cpu_held", int'(cpu_rst), 0);
    send(8'hC3);
    chk("run_cpu_rst", int'(cpu_rst), 1);

    // Address wrap with valid gaps
    send(8'hA5); send(8'hFE); send(8'h03);
    chk("wrap_cpu_held", int'(cpu_rst), 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      send(p32[i]);
      push(8'(8'hFE + i), p32[i], cyc);
    end
    idle(2);
    chk("wrap_done_busy", int'(busy), 0);

    // Unknown command sets sticky err; C3 clears it
    chk("err_before", int'(err), 0);
    send(8'h77);
    chk("err_set", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_in_ready", int'(in_ready), 1);
    idle(2);
    chk("err_sticky", int'(err), 1);
    send(8'hC3);
    chk("err_clear", int'(err), 0);
    chk("err_cpu_rst", int'(cpu_rst), 1);

    // Full 256-byte frame from 8Bh (length byte 0), wrapping to 8Ah
    send(8'hA5); send(8'h8B); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i) ^ 8'h3C;
      send(b);
      push(8'(8'h8B + i), b, cyc);
    end
    chk("full_done_busy", int'(busy), 0);
    send(8'hC3);
    chk("full_cpu_rst", int'(cpu_rst), 1);

    // Repeat frame aborted by reset right after payload byte 10
    send(8'hA5); send(8'h8B); send(8'h00);
    for (int i = 0; i < 10; i++) begin
      b = 8'(i) + 8'hA0;
      send(b);
      if (i < 9) push(8'(8'h8B + i), b, cyc);
    end
    rst = 1'b0;
    #1;
    chk("abort_mem_write", int'(mem_write), 0);
    chk("abort_cpu_rst", int'(cpu_rst), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    // First byte after reset is a command: 10h is unknown, so no write
    send(8'h10);
    chk("post_rst_cmd_err", int'(err), 1);
    chk("post_rst_busy", int'(busy), 0);
    send(8'hC3);
    chk("post_rst_cpu_rst", int'(cpu_rst), 1);
    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
